// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALU/immediate selectors, FSM states and instruction classes for multicycle_control
package ctrl_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    // ALU covers every register-writing non-memory instruction (OP, OP-IMM,
    // JAL, JALR, LUI, AUIPC); NOP retires straight from EXEC.
    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_NOP    = 3'd4
    } class_e;

endpackage

// File: rtl/mc_decode_lut.sv
// rtl/mc_decode_lut.sv - combinational opcode/funct3 lookup to class, alu_op, alu_src, imm_sel and illegal (MC_FENCE_EN)
module mc_decode_lut
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output class_e     cls,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output imm_sel_e   imm_sel,
    output logic       illegal
);

    always_comb begin
        cls     = CLS_ALU;
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        imm_sel = IMM_I;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                cls     = CLS_LOAD;
                alu_src = 1'b1;
            end
            OPC_STORE: begin
                cls     = CLS_STORE;
                alu_src = 1'b1;
                imm_sel = IMM_S;
            end
            OPC_BRANCH: begin
                cls     = CLS_BRANCH;
                alu_op  = ALU_BRANCH;
                imm_sel = IMM_B;
            end
            OPC_OP_IMM: begin
                alu_op  = ALU_FUNCT;
                alu_src = 1'b1;
            end
            OPC_OP: begin
                alu_op  = ALU_FUNCT;
            end
            OPC_JAL: begin
                alu_src = 1'b1;
                imm_sel = IMM_J;
            end
            OPC_JALR: begin
                alu_src = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                alu_src = 1'b1;
                imm_sel = IMM_U;
            end
`ifdef MC_FENCE_EN
            OPC_MISC_MEM: begin
                cls     = CLS_NOP;
            end
`else
            OPC_MISC_MEM: begin
                illegal = 1'b1;
            end
`endif
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I controller FSM with memory handshakes, timeout and illegal trap (MC_FENCE_EN)
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       dmem_req,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       branch,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic [2:0] imm_sel,
    output logic       busy,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state_o
);

    state_e          state_q, state_d;
    class_e          cls_q, cls_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic            alu_src_q, alu_src_d;
    imm_sel_e        imm_sel_q, imm_sel_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    class_e          lut_cls;
    logic [1:0]      lut_alu_op;
    logic            lut_alu_src;
    imm_sel_e        lut_imm_sel;
    logic            lut_illegal;

    logic            to_limit;
    state_e          retire_state;

    // funct7_5 goes straight to the ALU control block; nothing here decodes it.
    logic            unused_funct7_5;
    assign unused_funct7_5 = funct7_5;

    mc_decode_lut u_decode_lut (
        .opcode  (opcode),
        .funct3  (funct3),
        .cls     (lut_cls),
        .alu_op  (lut_alu_op),
        .alu_src (lut_alu_src),
        .imm_sel (lut_imm_sel),
        .illegal (lut_illegal)
    );

    // Counter equal to the limit means this is the last wait cycle allowed;
    // a ready in the same cycle still completes the access.
    assign to_limit     = (MEM_TIMEOUT != 0) && (to_cnt_q == TO_W'(MEM_TIMEOUT));
    assign retire_state = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_op_d   = alu_op_q;
        alu_src_d  = alu_src_q;
        imm_sel_d  = imm_sel_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        to_cnt_d   = '0;

        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        imm_sel    = IMM_I;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (to_limit) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                cls_d     = lut_cls;
                alu_op_d  = lut_alu_op;
                alu_src_d = lut_alu_src;
                imm_sel_d = lut_imm_sel;
                if (lut_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op  = alu_op_q;
                alu_src = alu_src_q;
                imm_sel = imm_sel_q;
                case (cls_q)
                    CLS_BRANCH: begin
                        // pc_write is qualified by the compare result in the datapath.
                        branch   = 1'b1;
                        pc_write = 1'b1;
                        state_d  = retire_state;
                    end
                    CLS_NOP: begin
                        pc_write = 1'b1;
                        state_d  = retire_state;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_d = S_MEM;
                    end
                    default: begin
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                alu_op    = alu_op_q;
                alu_src   = alu_src_q;
                imm_sel   = imm_sel_q;
                dmem_req  = 1'b1;
                mem_read  = (cls_q == CLS_LOAD);
                mem_write = (cls_q == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_q == CLS_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = retire_state;
                    end
                end else if (to_limit) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WB: begin
                alu_op     = alu_op_q;
                alu_src    = alu_src_q;
                imm_sel    = imm_sel_q;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (cls_q == CLS_LOAD);
                state_d    = retire_state;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_ALU;
            alu_op_q  <= ALU_ADD;
            alu_src_q <= 1'b0;
            imm_sel_q <= IMM_I;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            imm_sel_q <= imm_sel_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven and randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int TO = 4;

    localparam int P_IDLE   = 0;
    localparam int P_FETCH  = 1;
    localparam int P_DECODE = 2;
    localparam int P_EXEC   = 3;
    localparam int P_MEM    = 4;
    localparam int P_WB     = 5;
    localparam int P_TRAP   = 6;

    localparam int K_ALU    = 0;
    localparam int K_LOAD   = 1;
    localparam int K_STORE  = 2;
    localparam int K_BRANCH = 3;
    localparam int K_NOP    = 4;
    localparam int K_ILL    = 5;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        int         iw;
        int         dw;
        bit         run_after;
        int         kind;
        logic [1:0] aop;
        logic       asrc;
        logic [2:0] isel;
    } vec_t;

    logic       clk, rst, run, funct7_5, imem_ready, dmem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       imem_req, ir_write, dmem_req, pc_write, reg_write;
    logic       mem_read, mem_write, mem_to_reg, branch, alu_src;
    logic       busy, illegal, timeout;
    logic [1:0] alu_op;
    logic [2:0] imm_sel, state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int m_state;
    bit m_ill, m_to;

    vec_t tbl[18];

    multicycle_control #(.MEM_TIMEOUT(TO), .TO_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req),
        .pc_write(pc_write), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
        .alu_op(alu_op), .alu_src(alu_src), .imm_sel(imm_sel), .busy(busy),
        .illegal(illegal), .timeout(timeout), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected output bundle for one cycle of a given phase.
    function automatic logic [20:0] exp_out(int ph, bit rdy, int k, logic [1:0] aop,
                                            logic asrc, logic [2:0] isel);
        logic imr, irw, dmr, pcw, rw, mr, mw, m2r, br, as, bz;
        logic [1:0] ao;
        logic [2:0] is;
        imr = 0; irw = 0; dmr = 0; pcw = 0; rw = 0; mr = 0; mw = 0; m2r = 0; br = 0;
        ao = 2'b00; as = 0; is = 3'd0;
        if (ph == P_EXEC || ph == P_MEM || ph == P_WB) begin
            ao = aop; as = asrc; is = isel;
        end
        if (ph == P_FETCH) begin
            imr = 1; irw = rdy;
        end else if (ph == P_EXEC) begin
            br  = (k == K_BRANCH);
            pcw = (k == K_BRANCH) || (k == K_NOP);
        end else if (ph == P_MEM) begin
            dmr = 1; mr = (k == K_LOAD); mw = (k == K_STORE);
            pcw = (k == K_STORE) && rdy;
        end else if (ph == P_WB) begin
            rw = 1; pcw = 1; m2r = (k == K_LOAD);
        end
        bz = (ph != P_IDLE) && (ph != P_TRAP);
        return {imr, irw, dmr, pcw, rw, mr, mw, m2r, br, ao, as, is, bz, m_ill, m_to, 3'(ph)};
    endfunction

    task automatic check(input logic [20:0] expv, input string nm);
        logic [20:0] got;
        got = {imem_req, ir_write, dmem_req, pc_write, reg_write, mem_read, mem_write,
               mem_to_reg, branch, alu_op, alu_src, imm_sel, busy, illegal, timeout, state_o};
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, expv, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit ir, input bit dr, input logic [20:0] expv,
                       input string nm);
        @(negedge clk);
        run = r; imem_ready = ir; dmem_ready = dr;
        #1;
        check(expv, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; run = 0; imem_ready = 0; dmem_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        m_ill = 0; m_to = 0; m_state = P_IDLE;
        #1;
        check(exp_out(P_IDLE, 0, K_ALU, 2'b00, 0, 3'd0), "reset_idle");
    endtask

    task automatic trap_tail();
        m_state = P_TRAP;
        repeat (3) cyc(rb(), rb(), rb(), exp_out(P_TRAP, 0, K_ALU, 2'b00, 0, 3'd0), "trap_hold");
    endtask

    // Sequences one instruction through the phases the specification prescribes.
    task automatic do_instr(input vec_t v);
        bit rdy;
        bit memk;
        memk = (v.kind == K_LOAD) || (v.kind == K_STORE);
        opcode = v.opc; funct3 = v.f3; funct7_5 = rb();
        if (m_state == P_IDLE)
            cyc(1, rb(), rb(), exp_out(P_IDLE, 0, v.kind, v.aop, v.asrc, v.isel), "idle_start");
        for (int k = 0; k <= v.iw; k++) begin
            rdy = (k == v.iw);
            cyc(1, rdy, rb(), exp_out(P_FETCH, rdy, v.kind, v.aop, v.asrc, v.isel), "fetch");
            if (!rdy && k == TO) begin
                m_to = 1; trap_tail(); return;
            end
        end
        cyc(memk ? 1'b1 : v.run_after, rb(), rb(),
            exp_out(P_DECODE, 0, v.kind, v.aop, v.asrc, v.isel), "decode");
        if (v.kind == K_ILL) begin
            m_ill = 1; trap_tail(); return;
        end
        cyc(memk ? 1'b1 : v.run_after, rb(), rb(),
            exp_out(P_EXEC, 0, v.kind, v.aop, v.asrc, v.isel), "exec");
        if (memk) begin
            for (int k = 0; k <= v.dw; k++) begin
                rdy = (k == v.dw);
                cyc(v.run_after, rb(), rdy, exp_out(P_MEM, rdy, v.kind, v.aop, v.asrc, v.isel), "mem");
                if (!rdy && k == TO) begin
                    m_to = 1; trap_tail(); return;
                end
            end
        end
        if (v.kind == K_ALU || v.kind == K_LOAD)
            cyc(v.run_after, rb(), rb(), exp_out(P_WB, 0, v.kind, v.aop, v.asrc, v.isel), "wb");
        m_state = v.run_after ? P_FETCH : P_IDLE;
    endtask

    function automatic vec_t ref_decode(logic [6:0] opc, logic [2:0] f3);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.iw = 0; v.dw = 0; v.run_after = 1;
        v.kind = K_ALU; v.aop = 2'b00; v.asrc = 1; v.isel = 3'd0;
        case (opc)
            7'b0000011: v.kind = K_LOAD;
            7'b0100011: begin v.kind = K_STORE; v.isel = 3'd1; end
            7'b1100011: begin v.kind = K_BRANCH; v.aop = 2'b01; v.asrc = 0; v.isel = 3'd2; end
            7'b0010011: v.aop = 2'b10;
            7'b0110011: begin v.aop = 2'b10; v.asrc = 0; end
            7'b1101111: v.isel = 3'd4;
            7'b1100111: if (f3 != 0) v.kind = K_ILL;
            7'b0110111, 7'b0010111: v.isel = 3'd3;
`ifdef MC_FENCE_EN
            7'b0001111: begin v.kind = K_NOP; v.asrc = 0; end
`endif
            default: v.kind = K_ILL;
        endcase
        return v;
    endfunction

    initial begin
        logic [6:0] legal_opc[10];
        vec_t v;
        rst = 1; run = 0; opcode = 0; funct3 = 0; funct7_5 = 0;
        imem_ready = 0; dmem_ready = 0;
        m_ill = 0; m_to = 0; m_state = P_IDLE;

        tbl[0]  = '{7'b0010011, 3'd0, 2, 0, 1'b1, K_ALU,    2'b10, 1'b1, 3'd0};
        tbl[1]  = '{7'b0000011, 3'd2, 0, 3, 1'b1, K_LOAD,   2'b00, 1'b1, 3'd0};
        tbl[2]  = '{7'b0100011, 3'd2, 1, 0, 1'b1, K_STORE,  2'b00, 1'b1, 3'd1};
        tbl[3]  = '{7'b1100011, 3'd0, 0, 0, 1'b1, K_BRANCH, 2'b01, 1'b0, 3'd2};
        tbl[4]  = '{7'b0110011, 3'd0, 4, 0, 1'b1, K_ALU,    2'b10, 1'b0, 3'd0};
        tbl[5]  = '{7'b1101111, 3'd5, 0, 0, 1'b1, K_ALU,    2'b00, 1'b1, 3'd4};
        tbl[6]  = '{7'b1100111, 3'd0, 1, 0, 1'b0, K_ALU,    2'b00, 1'b1, 3'd0};
        tbl[7]  = '{7'b0110111, 3'd7, 0, 0, 1'b1, K_ALU,    2'b00, 1'b1, 3'd3};
        tbl[8]  = '{7'b0010111, 3'd1, 3, 0, 1'b1, K_ALU,    2'b00, 1'b1, 3'd3};
        tbl[9]  = '{7'b0000011, 3'd0, 0, 4, 1'b0, K_LOAD,   2'b00, 1'b1, 3'd0};
        tbl[10] = '{7'b0100011, 3'd0, 0, 2, 1'b0, K_STORE,  2'b00, 1'b1, 3'd1};
        tbl[11] = '{7'b1111111, 3'd0, 0, 0, 1'b1, K_ILL,    2'b00, 1'b0, 3'd0};
        tbl[12] = '{7'b1100111, 3'd1, 0, 0, 1'b1, K_ILL,    2'b00, 1'b0, 3'd0};
`ifdef MC_FENCE_EN
        tbl[13] = '{7'b0001111, 3'd0, 1, 0, 1'b1, K_NOP,    2'b00, 1'b0, 3'd0};
`else
        tbl[13] = '{7'b0001111, 3'd0, 1, 0, 1'b1, K_ILL,    2'b00, 1'b0, 3'd0};
`endif
        tbl[14] = '{7'b0010011, 3'd0, 5, 0, 1'b1, K_ALU,    2'b10, 1'b1, 3'd0};
        tbl[15] = '{7'b0000011, 3'd2, 0, 6, 1'b1, K_LOAD,   2'b00, 1'b1, 3'd0};
        tbl[16] = '{7'b0100011, 3'd2, 2, 5, 1'b1, K_STORE,  2'b00, 1'b1, 3'd1};
        tbl[17] = '{7'b1100011, 3'd1, 0, 0, 1'b0, K_BRANCH, 2'b01, 1'b0, 3'd2};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            do_instr(tbl[i]);
            if (m_state == P_TRAP) do_reset();
        end

        // Reset in the middle of a load: the access must vanish immediately.
        do_reset();
        opcode = 7'b0000011; funct3 = 3'd2;
        cyc(1, 0, 0, exp_out(P_IDLE, 0, K_LOAD, 2'b00, 1, 3'd0), "rst_mid_idle");
        cyc(1, 1, 0, exp_out(P_FETCH, 1, K_LOAD, 2'b00, 1, 3'd0), "rst_mid_fetch");
        cyc(1, 0, 0, exp_out(P_DECODE, 0, K_LOAD, 2'b00, 1, 3'd0), "rst_mid_decode");
        cyc(1, 0, 0, exp_out(P_EXEC, 0, K_LOAD, 2'b00, 1, 3'd0), "rst_mid_exec");
        cyc(1, 0, 0, exp_out(P_MEM, 0, K_LOAD, 2'b00, 1, 3'd0), "rst_mid_mem");
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; run = 0;
        m_state = P_IDLE;
        #1;
        check(exp_out(P_IDLE, 0, K_ALU, 2'b00, 0, 3'd0), "rst_mid_abort");

        legal_opc = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
        for (int n = 0; n < 60; n++) begin
            logic [6:0] opc;
            logic [2:0] f3;
            if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
            else opc = legal_opc[$urandom_range(0, 9)];
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            v = ref_decode(opc, f3);
            v.iw = ($urandom_range(0, 11) == 0) ? 5 : $urandom_range(0, 4);
            v.dw = ($urandom_range(0, 11) == 0) ? 6 : $urandom_range(0, 4);
            v.run_after = ($urandom_range(0, 3) != 0);
            do_instr(v);
            if (m_state == P_TRAP) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
